// File: rtl/fp_stage_skid_buf.sv
// Two-entry skid buffer that carries one {sign, exponent, mantissa} operand between FP datapath stages.
// in_ready and out_valid are decoded from registered state only, so backpressure never forms a combinational path.
module fp_stage_skid_buf #(
    parameter int MW = 24,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW-1:0] in_m,
    input  logic [EW-1:0] in_e,
    input  logic          in_s,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] out_m,
    output logic [EW-1:0] out_e,
    output logic          out_s,
    output logic [1:0]    count
);

    localparam int DW = MW + EW + 1;

    // The encoding is chosen so that the state value is the occupancy itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_main;
    logic [DW-1:0] r_skid;
    logic [DW-1:0] w_in_word;
    logic          w_in_fire;
    logic          w_out_fire;

    assign w_in_word  = {in_s, in_e, in_m};
    assign in_ready   = (r_state != ST_FULL);
    assign out_valid  = (r_state != ST_EMPTY);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign count      = 2'(r_state);
    assign {out_s, out_e, out_m} = r_main;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (flush) begin
            // A concurrent pop still completes downstream; a concurrent push is dropped.
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_main  <= w_in_word;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main <= w_in_word;
                    end else if (w_in_fire) begin
                        r_skid  <= w_in_word;
                        r_state <= ST_FULL;
                    end else if (w_out_fire) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        r_main  <= r_skid;
                        r_state <= ST_ONE;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: doc/fp_stage_skid_buf.md
# fp_stage_skid_buf

Parametrised elastic pipeline register for the floating-point datapath. It carries one {sign, exponent, mantissa} operand between two datapath stages, such as between normalisation and rounding in the multiplier. It replaces bare clocked stage registers with a 2-entry skid buffer that uses a valid/ready handshake. The result is full throughput with registered backpressure, plus synchronous flush and occupancy reporting.

## Interface
- MW, 24: mantissa width in bits, including the hidden bit; ≥1.
- EW, 8: exponent width in bits; ≥1.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all buffered entries.
- in_valid  input  1  upstream holds a valid operand.
- in_ready  output  1  buffer accepts an operand this cycle.
- in_m  input  MW  upstream mantissa.
- in_e  input  EW  upstream exponent.
- in_s  input  1  upstream sign.
- out_valid  output  1  out_* holds a valid operand.
- out_ready  input  1  downstream accepts this cycle.
- out_m  output  MW  downstream mantissa.
- out_e  output  EW  downstream exponent.
- out_s  output  1  downstream sign.
- count  output  2  occupancy: 0, 1 or 2.

## Operation
- Storage: main register (drives out_*) and skid register, each {s, e, m}, MW+EW+1 bits.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States: EMPTY (count 0), ONE (count 1, main valid), FULL (count 2, main and skid valid).
- out_valid = (state != EMPTY). in_ready = (state != FULL). Both are decoded from registered state only, with no combinational path from in_valid or out_ready.
- Transitions in EMPTY:
  - in_fire: main ← in, go to ONE.
  - otherwise: stay in EMPTY.
- Transitions in ONE:
  - in_fire & out_fire: main ← in, stay in ONE.
  - in_fire & !out_fire: skid ← in, go to FULL.
  - !in_fire & out_fire: go to EMPTY.
  - otherwise: hold.
- Transitions in FULL (in_ready = 0, so no in_fire):
  - out_fire: main ← skid, go to ONE.
  - otherwise: hold.
- Ordering is strict FIFO; no operand is dropped or duplicated except by flush.
- Stability: while out_valid & !out_ready, out_m/out_e/out_s are held constant.
- On pop to EMPTY, the main register keeps its last value; outputs are don't-care but stable.
- Fields pass through bit-exact: no arithmetic, no width conversion.
- flush has priority over all handshakes. On the next edge the state goes to EMPTY and count to 0.
  - An in_fire in the same cycle as flush is discarded.
  - An out_fire in the same cycle as flush is still consumed downstream, since its data was already presented.
- Reset mid-operation discards all entries.

## Timing
- Reset values: state EMPTY, out_valid 0, in_ready 1, count 0, out_m 0, out_e 0, out_s 0, skid register 0.
- Latency: an operand accepted at edge N appears on out_* with out_valid = 1 after edge N, whenever the buffer was EMPTY or popped at that edge.
- Throughput: 1 operand per cycle sustained while out_ready = 1.
- Backpressure: out_ready dropping for one cycle with in_valid held leads to FULL. in_ready is 0 in the following cycle and returns to 1 one cycle after the next out_fire.
- count updates on the same edge as the state.
- flush takes effect at the edge where it is sampled high. out_valid is 0 and in_ready is 1 in the following cycle.
- Asserting rst_n low forces the reset values immediately. Deasserting it synchronously to clk allows in_fire on the first subsequent edge.

## Test plan
- Reset then stream: hold out_ready = 1 and push 8 operands (m = 0x800000 + i, e = 0x7F + i, s = i[0]) back-to-back. Required: 8 outputs in order, each 1 cycle after acceptance, count never exceeds 1, in_ready stays 1.
- Stall: out_ready = 0 while pushing A then B. Required: count goes 1 then 2, in_ready = 0 after B, out_* = A held stable. Then raising out_ready delivers A then B on consecutive cycles and count returns to 0.
- Random stall: 1000 operands with random in_valid/out_ready at 50%. Required: scoreboard order and values match exactly, no valid output while count = 0, in_ready = 0 exactly when count = 2.
- Flush when FULL with in_valid = 1 in the same cycle. Required: next cycle count = 0, out_valid = 0, in_ready = 1, and the flushed and concurrent operands never appear.
- Asynchronous reset when FULL, applied mid-cycle. Required: out_valid, count and out_* go to 0 immediately, and the first push after release appears on the output 1 cycle later.
- Parameter sweep at MW = 11, EW = 5 (half precision) and MW = 53, EW = 11 (double). Push all-ones and alternating 0xA…A fields. Required: bit-exact pass-through.
